// File: rtl/rename_pkg.sv
// rename_pkg: shared sizes, physical register type, output record and free-list encoder
package rename_pkg;
  localparam int ARCH_REGS = 32;
  localparam int NUM_PHYS = 64;
  localparam int PHYS_W = $clog2(NUM_PHYS);
  typedef logic [PHYS_W-1:0] phys_reg_t;
  typedef logic [4:0] arch_reg_t;
  typedef struct packed {
    logic        valid;
    phys_reg_t   phys_a;
    phys_reg_t   phys_b;
    phys_reg_t   phys_dest;
    phys_reg_t   old_phys_dest;
    logic        reg_write;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  alu_control;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  shift_amount;
    logic        has_immediate;
    logic [31:0] immediate;
  } rename_out_t;
  function automatic phys_reg_t lowest_set(input logic [NUM_PHYS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_PHYS - 1; i >= 0; i--) if (v[i]) lowest_set = phys_reg_t'(i);
  endfunction
endpackage

// File: rtl/rename_stage_if.sv
// rename_stage_if: decode-side, issue-side and commit-side signals of the rename stage
// master: surrounding pipeline (drives *_IN, Stall, Flush, commit); slave: rename_stage
interface rename_stage_if;
  import rename_pkg::*;
  logic        Valid_IN;
  logic        Ready_OUT;
  logic [31:0] Instr_IN;
  logic [31:0] PC_IN;
  arch_reg_t   ReadRegA_IN;
  arch_reg_t   ReadRegB_IN;
  arch_reg_t   WriteReg_IN;
  logic        RegWrite_IN;
  logic [5:0]  ALU_Control_IN;
  logic        MemRead_IN;
  logic        MemWrite_IN;
  logic [4:0]  ShiftAmount_IN;
  logic        HasImmediate_IN;
  logic [31:0] Immediate_IN;
  logic        Stall_IN;
  logic        Valid_OUT;
  phys_reg_t   PhysA_OUT;
  phys_reg_t   PhysB_OUT;
  phys_reg_t   PhysDest_OUT;
  phys_reg_t   OldPhysDest_OUT;
  logic        RegWrite_OUT;
  logic [31:0] Instr_OUT;
  logic [31:0] PC_OUT;
  logic [5:0]  ALU_Control_OUT;
  logic        MemRead_OUT;
  logic        MemWrite_OUT;
  logic [4:0]  ShiftAmount_OUT;
  logic        HasImmediate_OUT;
  logic [31:0] Immediate_OUT;
  logic        Commit_Valid_IN;
  arch_reg_t   Commit_ArchReg_IN;
  phys_reg_t   Commit_PhysReg_IN;
  phys_reg_t   Commit_OldPhys_IN;
  logic        Flush_IN;
  modport master (
    output Valid_IN, Instr_IN, PC_IN, ReadRegA_IN, ReadRegB_IN, WriteReg_IN, RegWrite_IN,
           ALU_Control_IN, MemRead_IN, MemWrite_IN, ShiftAmount_IN, HasImmediate_IN,
           Immediate_IN, Stall_IN, Commit_Valid_IN, Commit_ArchReg_IN, Commit_PhysReg_IN,
           Commit_OldPhys_IN, Flush_IN,
    input  Ready_OUT, Valid_OUT, PhysA_OUT, PhysB_OUT, PhysDest_OUT, OldPhysDest_OUT,
           RegWrite_OUT, Instr_OUT, PC_OUT, ALU_Control_OUT, MemRead_OUT, MemWrite_OUT,
           ShiftAmount_OUT, HasImmediate_OUT, Immediate_OUT
  );
  modport slave (
    input  Valid_IN, Instr_IN, PC_IN, ReadRegA_IN, ReadRegB_IN, WriteReg_IN, RegWrite_IN,
           ALU_Control_IN, MemRead_IN, MemWrite_IN, ShiftAmount_IN, HasImmediate_IN,
           Immediate_IN, Stall_IN, Commit_Valid_IN, Commit_ArchReg_IN, Commit_PhysReg_IN,
           Commit_OldPhys_IN, Flush_IN,
    output Ready_OUT, Valid_OUT, PhysA_OUT, PhysB_OUT, PhysDest_OUT, OldPhysDest_OUT,
           RegWrite_OUT, Instr_OUT, PC_OUT, ALU_Control_OUT, MemRead_OUT, MemWrite_OUT,
           ShiftAmount_OUT, HasImmediate_OUT, Immediate_OUT
  );
endinterface

// File: rtl/rename_stage_free_list.sv
// free_list: physical register free vector with lowest-free encoder and free count
// in: clk, rst, alloc (take p), free_en/free_idx (release), restore/restore_vec (flush rebuild)
// out: p (lowest free register), empty (no free register)
module free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc,
  input  logic                free_en,
  input  phys_reg_t           free_idx,
  input  logic                restore,
  input  logic [NUM_PHYS-1:0] restore_vec,
  output phys_reg_t           p,
  output logic                empty
);
  localparam logic [NUM_PHYS-1:0] RESET_VEC = {{(NUM_PHYS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
  localparam logic [PHYS_W:0] RESET_COUNT = (PHYS_W + 1)'(NUM_PHYS - ARCH_REGS);
  logic [NUM_PHYS-1:0] vec_q, vec_d;
  logic [PHYS_W:0] count_q, count_d;
  assign p = lowest_set(vec_q);
  assign empty = count_q == '0;
  always_comb begin
    vec_d = vec_q;
    if (alloc) vec_d[p] = 1'b0;
    if (free_en) vec_d[free_idx] = 1'b1;
    if (restore) vec_d = restore_vec;
    // after a flush every architectural register owns exactly one physical register
    count_d = restore ? RESET_COUNT : count_q - {{PHYS_W{1'b0}}, alloc} + {{PHYS_W{1'b0}}, free_en};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= RESET_VEC;
      count_q <= RESET_COUNT;
    end else begin
      vec_q <= vec_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/rename_stage.sv
// rename_stage: maps architectural registers to physical ones, allocating destinations from a free list
// ports: CLK, RESET (sync, active-high), bus (rename_stage_if.slave: decode input, issue output, commit, flush)
module rename_stage
  import rename_pkg::*;
(
  input logic           CLK,
  input logic           RESET,
  rename_stage_if.slave bus
);
  phys_reg_t rat_q [ARCH_REGS];
  phys_reg_t rat_d [ARCH_REGS];
  phys_reg_t rrat_q [ARCH_REGS];
  phys_reg_t rrat_d [ARCH_REGS];
  rename_out_t out_q, out_d;
  logic [NUM_PHYS-1:0] restore_vec;
  phys_reg_t p;
  logic empty, ready, accept, alloc, free_en;
  assign ready = !bus.Stall_IN && !bus.Flush_IN && !RESET && !empty;
  assign accept = bus.Valid_IN && ready;
  assign alloc = accept && bus.RegWrite_IN && bus.WriteReg_IN != '0;
  assign free_en = bus.Commit_Valid_IN && bus.Commit_ArchReg_IN != '0;
  free_list u_fl (
    .clk(CLK),
    .rst(RESET),
    .alloc(alloc),
    .free_en(free_en),
    .free_idx(bus.Commit_OldPhys_IN),
    .restore(bus.Flush_IN),
    .restore_vec(restore_vec),
    .p(p),
    .empty(empty)
  );
  // flush restores from the retirement map including this cycle's commit
  always_comb begin
    rrat_d = rrat_q;
    if (bus.Commit_Valid_IN) rrat_d[bus.Commit_ArchReg_IN] = bus.Commit_PhysReg_IN;
    restore_vec = '1;
    for (int i = 0; i < ARCH_REGS; i++) restore_vec[rrat_d[i]] = 1'b0;
    rat_d = rat_q;
    if (alloc) rat_d[bus.WriteReg_IN] = p;
    if (bus.Flush_IN) rat_d = rrat_d;
  end
  // sources read rat_q so a source equal to the destination sees the old mapping
  always_comb begin
    out_d = out_q;
    if (bus.Flush_IN) out_d.valid = 1'b0;
    else if (accept) begin
      out_d.valid = 1'b1;
      out_d.phys_a = rat_q[bus.ReadRegA_IN];
      out_d.phys_b = rat_q[bus.ReadRegB_IN];
      out_d.phys_dest = alloc ? p : '0;
      out_d.old_phys_dest = alloc ? rat_q[bus.WriteReg_IN] : '0;
      out_d.reg_write = bus.RegWrite_IN;
      out_d.instr = bus.Instr_IN;
      out_d.pc = bus.PC_IN;
      out_d.alu_control = bus.ALU_Control_IN;
      out_d.mem_read = bus.MemRead_IN;
      out_d.mem_write = bus.MemWrite_IN;
      out_d.shift_amount = bus.ShiftAmount_IN;
      out_d.has_immediate = bus.HasImmediate_IN;
      out_d.immediate = bus.Immediate_IN;
    end else if (!bus.Stall_IN) out_d.valid = 1'b0;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= phys_reg_t'(i);
        rrat_q[i] <= phys_reg_t'(i);
      end
      out_q <= '0;
    end else begin
      rat_q <= rat_d;
      rrat_q <= rrat_d;
      out_q <= out_d;
    end
  end
  assign bus.Ready_OUT = ready;
  assign bus.Valid_OUT = out_q.valid;
  assign bus.PhysA_OUT = out_q.phys_a;
  assign bus.PhysB_OUT = out_q.phys_b;
  assign bus.PhysDest_OUT = out_q.phys_dest;
  assign bus.OldPhysDest_OUT = out_q.old_phys_dest;
  assign bus.RegWrite_OUT = out_q.reg_write;
  assign bus.Instr_OUT = out_q.instr;
  assign bus.PC_OUT = out_q.pc;
  assign bus.ALU_Control_OUT = out_q.alu_control;
  assign bus.MemRead_OUT = out_q.mem_read;
  assign bus.MemWrite_OUT = out_q.mem_write;
  assign bus.ShiftAmount_OUT = out_q.shift_amount;
  assign bus.HasImmediate_OUT = out_q.has_immediate;
  assign bus.Immediate_OUT = out_q.immediate;
endmodule
